// File: rtl/mor1kx_dmmu_nway.sv
// mor1kx_dmmu_nway: N-way set-associative data MMU, TLB programmed over the SPR bus.
// Hardware page-table reload is built only when MOR1KX_DMMU_HW_RELOAD_EN is defined.
module mor1kx_dmmu_nway #(
    parameter int OPTION_OPERAND_WIDTH  = 32,
    parameter int OPTION_DMMU_SET_WIDTH = 4,
    parameter int OPTION_DMMU_WAYS      = 2,
    parameter int OPTION_DMMU_PAGE_BITS = 13
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            enable_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] virt_addr_match_i,
    input  logic                            op_load_i,
    input  logic                            op_store_i,
    input  logic                            supervisor_mode_i,
    output logic [OPTION_OPERAND_WIDTH-1:0] phys_addr_o,
    output logic                            cache_inhibit_o,
    output logic                            tlb_miss_o,
    output logic                            pagefault_o,
    output logic                            tlb_reload_req_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] tlb_reload_addr_o,
    input  logic                            tlb_reload_ack_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] tlb_reload_data_i,
    output logic                            tlb_reload_busy_o,
    output logic                            tlb_reload_pagefault_o,
    input  logic                            tlb_reload_pagefault_clear_i,
    input  logic [15:0]                     spr_bus_addr_i,
    input  logic                            spr_bus_we_i,
    input  logic                            spr_bus_stb_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] spr_bus_dat_i,
    output logic [OPTION_OPERAND_WIDTH-1:0] spr_bus_dat_o,
    output logic                            spr_bus_ack_o
);
    localparam int OW   = OPTION_OPERAND_WIDTH;
    localparam int PB   = OPTION_DMMU_PAGE_BITS;
    localparam int SW   = OPTION_DMMU_SET_WIDTH;
    localparam int WAYS = OPTION_DMMU_WAYS;
    localparam int SETS = 1 << SW;
    localparam int WI   = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam logic [2:0] WAYS3 = 3'(WAYS);

    // Perm nibble order is {SWE, SRE, UWE, URE}, i.e. translate bits 9..6.
    logic [OW-1:PB] r_mvpn  [WAYS][SETS];
    logic           r_mv    [WAYS][SETS];
    logic [OW-1:PB] r_tppn  [WAYS][SETS];
    logic           r_tci   [WAYS][SETS];
    logic [3:0]     r_tperm [WAYS][SETS];
    logic           r_ack;
    logic [OW-1:0]  r_dat;

    logic [SW-1:0]  w_set;
    logic           w_hit;
    logic [OW-1:PB] w_ppn;
    logic           w_ci;
    logic [3:0]     w_perm;
    logic           w_en_hit, w_re, w_we;

    assign w_set = virt_addr_match_i[PB+SW-1:PB];

    always_comb begin
        w_hit  = 1'b0;
        w_ppn  = '0;
        w_ci   = 1'b0;
        w_perm = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!w_hit && r_mv[WI'(w)][w_set] &&
                r_mvpn[WI'(w)][w_set] == virt_addr_match_i[OW-1:PB]) begin
                w_hit  = 1'b1;
                w_ppn  = r_tppn[WI'(w)][w_set];
                w_ci   = r_tci[WI'(w)][w_set];
                w_perm = r_tperm[WI'(w)][w_set];
            end
        end
    end

    assign w_en_hit        = enable_i & w_hit;
    assign phys_addr_o     = w_en_hit ? {w_ppn, virt_addr_match_i[PB-1:0]} : virt_addr_match_i;
    assign cache_inhibit_o = w_en_hit & w_ci;
    assign tlb_miss_o      = enable_i & !w_hit;
    assign w_re            = supervisor_mode_i ? w_perm[2] : w_perm[0];
    assign w_we            = supervisor_mode_i ? w_perm[3] : w_perm[1];
    assign pagefault_o     = w_en_hit & ((op_load_i & !w_re) | (op_store_i & !w_we)) &
                             !tlb_reload_busy_o;

    // SPR group 1: DMMUCR at offset 0, TLB ways from 0x200 upwards.
    logic          w_grp1, w_tlb, w_cr, w_strans, w_way_ok, w_spr_wr, w_spr_rd;
    logic [1:0]    w_sway;
    logic [WI-1:0] w_sway_i;
    logic [SW-1:0] w_sidx;
    logic [OW-1:0] w_rdata;
    logic [OW-1:10] w_cr_base;

    assign w_grp1   = spr_bus_addr_i[15:11] == 5'd1;
    assign w_tlb    = w_grp1 & (spr_bus_addr_i[10] | spr_bus_addr_i[9]);
    assign w_cr     = w_grp1 & (spr_bus_addr_i[10:0] == 11'd0);
    assign w_sway   = {spr_bus_addr_i[10], spr_bus_addr_i[8]};
    assign w_sway_i = w_sway[WI-1:0];
    assign w_way_ok = {1'b0, w_sway} < WAYS3;
    assign w_strans = spr_bus_addr_i[7];
    assign w_sidx   = spr_bus_addr_i[SW-1:0];
    assign w_spr_wr = spr_bus_stb_i & spr_bus_we_i & w_grp1 & !r_ack;
    assign w_spr_rd = spr_bus_stb_i & !spr_bus_we_i & w_grp1 & !r_ack;

    always_comb begin
        w_rdata = '0;
        if (w_cr)
            w_rdata = {w_cr_base, 10'd0};
        else if (w_tlb && w_way_ok) begin
            if (w_strans)
                w_rdata = {r_tppn[w_sway_i][w_sidx], {(PB-10){1'b0}}, r_tperm[w_sway_i][w_sidx],
                           4'd0, r_tci[w_sway_i][w_sidx], 1'b0};
            else
                w_rdata = {r_mvpn[w_sway_i][w_sidx], {(PB-1){1'b0}}, r_mv[w_sway_i][w_sidx]};
        end
    end

    assign spr_bus_ack_o = r_ack;
    assign spr_bus_dat_o = r_dat;

    logic w_unused;
    assign w_unused = ^{spr_bus_dat_i, spr_bus_addr_i, tlb_reload_data_i, tlb_reload_ack_i,
                        tlb_reload_pagefault_clear_i};

`ifdef MOR1KX_DMMU_HW_RELOAD_EN
    typedef enum logic [1:0] {S_IDLE, S_PTR, S_PTE, S_FILL} state_t;
    state_t         r_state;
    logic [OW-1:10] r_cr_base;
    logic [WI-1:0]  r_victim [SETS];
    logic           r_req, r_rpf;
    logic [OW-1:0]  r_raddr;
    logic [OW-1:PB] r_va, r_pte_ppn;
    logic           r_pte_ci, r_pte_w, r_pte_u;
    logic           w_start;
    logic [SW-1:0]  w_fset;
    logic [WI-1:0]  w_vway;

    assign w_cr_base              = r_cr_base;
    assign w_start                = enable_i & !w_hit & (op_load_i | op_store_i) & (r_cr_base != '0);
    assign w_fset                 = r_va[PB+SW-1:PB];
    assign w_vway                 = r_victim[w_fset];
    assign tlb_reload_req_o       = r_req;
    assign tlb_reload_addr_o      = r_raddr;
    assign tlb_reload_busy_o      = (r_state != S_IDLE) | w_start;
    assign tlb_reload_pagefault_o = r_rpf;
`else
    assign w_cr_base              = '0;
    assign tlb_reload_req_o       = 1'b0;
    assign tlb_reload_addr_o      = '0;
    assign tlb_reload_busy_o      = 1'b0;
    assign tlb_reload_pagefault_o = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned w = 0; w < WAYS; w++)
                for (int unsigned s = 0; s < SETS; s++)
                    r_mv[WI'(w)][SW'(s)] <= 1'b0;
            r_ack <= 1'b0;
            r_dat <= '0;
`ifdef MOR1KX_DMMU_HW_RELOAD_EN
            for (int unsigned s = 0; s < SETS; s++)
                r_victim[SW'(s)] <= '0;
            r_cr_base <= '0;
            r_state   <= S_IDLE;
            r_req     <= 1'b0;
            r_raddr   <= '0;
            r_rpf     <= 1'b0;
`endif
        end else begin
            r_ack <= spr_bus_stb_i & w_grp1 & !r_ack;
            r_dat <= w_spr_rd ? w_rdata : '0;
            if (w_spr_wr && w_tlb && w_way_ok) begin
                if (w_strans) begin
                    r_tppn[w_sway_i][w_sidx]  <= spr_bus_dat_i[OW-1:PB];
                    r_tci[w_sway_i][w_sidx]   <= spr_bus_dat_i[1];
                    r_tperm[w_sway_i][w_sidx] <= spr_bus_dat_i[9:6];
                end else begin
                    r_mvpn[w_sway_i][w_sidx] <= spr_bus_dat_i[OW-1:PB];
                    r_mv[w_sway_i][w_sidx]   <= spr_bus_dat_i[0];
                end
            end
`ifdef MOR1KX_DMMU_HW_RELOAD_EN
            if (w_spr_wr && w_cr)
                r_cr_base <= spr_bus_dat_i[OW-1:10];
            if (tlb_reload_pagefault_clear_i)
                r_rpf <= 1'b0;
            case (r_state)
                S_IDLE: if (w_start) begin
                    r_state <= S_PTR;
                    r_req   <= 1'b1;
                    r_raddr <= {r_cr_base, virt_addr_match_i[31:24], 2'b00};
                    r_va    <= virt_addr_match_i[OW-1:PB];
                end
                S_PTR: if (!enable_i) begin
                    r_state <= S_IDLE;
                    r_req   <= 1'b0;
                end else if (tlb_reload_ack_i) begin
                    if (tlb_reload_data_i[31:13] == '0) begin
                        r_rpf   <= 1'b1;
                        r_req   <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_raddr <= {tlb_reload_data_i[31:13], r_va[23:13], 2'b00};
                        r_state <= S_PTE;
                    end
                end
                S_PTE: if (!enable_i) begin
                    r_state <= S_IDLE;
                    r_req   <= 1'b0;
                end else if (tlb_reload_ack_i) begin
                    r_req <= 1'b0;
                    if (!tlb_reload_data_i[10]) begin
                        r_rpf   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_pte_ppn <= tlb_reload_data_i[OW-1:PB];
                        r_pte_ci  <= tlb_reload_data_i[1];
                        r_pte_w   <= tlb_reload_data_i[7];
                        r_pte_u   <= tlb_reload_data_i[6];
                        r_state   <= S_FILL;
                    end
                end
                S_FILL: begin
                    r_state <= S_IDLE;
                    if (enable_i) begin
                        r_mvpn[w_vway][w_fset]  <= r_va;
                        r_mv[w_vway][w_fset]    <= 1'b1;
                        r_tppn[w_vway][w_fset]  <= r_pte_ppn;
                        r_tci[w_vway][w_fset]   <= r_pte_ci;
                        r_tperm[w_vway][w_fset] <= {r_pte_w, 1'b1, r_pte_w & r_pte_u, r_pte_u};
                        r_victim[w_fset] <= (w_vway == WI'(WAYS - 1)) ? '0 : w_vway + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            // Flush last so it overrides any write landing on the same edge.
            if (w_spr_wr && w_cr && spr_bus_dat_i[0])
                for (int unsigned w = 0; w < WAYS; w++)
                    for (int unsigned s = 0; s < SETS; s++)
                        r_mv[WI'(w)][SW'(s)] <= 1'b0;
`endif
        end
    end
endmodule

// File: tb/tb_mor1kx_dmmu_nway.sv
// Directed self-checking bench for mor1kx_dmmu_nway (reload tests when MOR1KX_DMMU_HW_RELOAD_EN).
module tb_mor1kx_dmmu_nway;
    logic        clk = 1'b0;
    logic        rst, en, ld, st, sup;
    logic [31:0] va, phys;
    logic        ci, miss, pf;
    logic        req, ack, busy, rpf, clr;
    logic [31:0] raddr, rdat;
    logic [15:0] saddr;
    logic        swe, sstb, sack;
    logic [31:0] sdat_i, sdat_o;
    logic [31:0] d;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    mor1kx_dmmu_nway #(
        .OPTION_OPERAND_WIDTH (32),
        .OPTION_DMMU_SET_WIDTH(4),
        .OPTION_DMMU_WAYS     (2),
        .OPTION_DMMU_PAGE_BITS(13)
    ) dut (
        .clk                         (clk),
        .rst                         (rst),
        .enable_i                    (en),
        .virt_addr_match_i           (va),
        .op_load_i                   (ld),
        .op_store_i                  (st),
        .supervisor_mode_i           (sup),
        .phys_addr_o                 (phys),
        .cache_inhibit_o             (ci),
        .tlb_miss_o                  (miss),
        .pagefault_o                 (pf),
        .tlb_reload_req_o            (req),
        .tlb_reload_addr_o           (raddr),
        .tlb_reload_ack_i            (ack),
        .tlb_reload_data_i           (rdat),
        .tlb_reload_busy_o           (busy),
        .tlb_reload_pagefault_o      (rpf),
        .tlb_reload_pagefault_clear_i(clr),
        .spr_bus_addr_i              (saddr),
        .spr_bus_we_i                (swe),
        .spr_bus_stb_i               (sstb),
        .spr_bus_dat_i               (sdat_i),
        .spr_bus_dat_o               (sdat_o),
        .spr_bus_ack_o               (sack)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic access(input logic [31:0] a, input logic l, input logic s,
                          input logic sv, input logic e);
        @(negedge clk);
        va = a; ld = l; st = s; sup = sv; en = e;
        #1;
    endtask

    task automatic spr_wr(input logic [15:0] a, input logic [31:0] v);
        @(negedge clk);
        saddr = a; sdat_i = v; swe = 1'b1; sstb = 1'b1;
        @(negedge clk);
        check_eq("spr_wr_ack", sack, 1);
        swe = 1'b0; sstb = 1'b0;
    endtask

    task automatic spr_rd(input logic [15:0] a, output logic [31:0] v);
        @(negedge clk);
        saddr = a; swe = 1'b0; sstb = 1'b1;
        @(negedge clk);
        check_eq("spr_rd_ack", sack, 1);
        v = sdat_o;
        sstb = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        for (int i = 0; i < 20 && !req; i++) @(negedge clk);
        #1;
        check_eq({tag, "_req"}, req, 1);
    endtask

    task automatic do_reload(input string tag, input logic [31:0] v, input logic [31:0] ptr_a,
                             input logic [31:0] ptr_d, input logic [31:0] pte_a,
                             input logic [31:0] pte_d);
        access(v, 1'b1, 1'b0, 1'b1, 1'b1);
        check_eq({tag, "_busy"}, busy, 1);
        wait_req(tag);
        check_eq({tag, "_ptr_addr"}, raddr, ptr_a);
        ack = 1'b1; rdat = ptr_d;
        @(negedge clk);
        ack = 1'b0;
        #1;
        check_eq({tag, "_pte_req"}, req, 1);
        check_eq({tag, "_pte_addr"}, raddr, pte_a);
        ack = 1'b1; rdat = pte_d;
        @(negedge clk);
        ack = 1'b0;
        for (int i = 0; i < 20 && busy; i++) @(negedge clk);
        #1;
        check_eq({tag, "_idle"}, busy, 0);
        check_eq({tag, "_hit"}, miss, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; en = 1'b0; va = '0; ld = 1'b0; st = 1'b0; sup = 1'b0;
        ack = 1'b0; rdat = '0; clr = 1'b0; saddr = '0; swe = 1'b0; sstb = 1'b0; sdat_i = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("rst_req", req, 0);
        check_eq("rst_addr", raddr, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_rpf", rpf, 0);
        check_eq("rst_ack", sack, 0);
        check_eq("rst_dat", sdat_o, 0);

        access(32'h0000_6abc, 1'b1, 1'b0, 1'b0, 1'b1);
        check_eq("empty_miss", miss, 1);
        check_eq("empty_phys", phys, 32'h0000_6abc);
        check_eq("empty_pf", pf, 0);

        spr_wr(16'h0B03, 32'h0000_6001);
        spr_wr(16'h0B83, 32'h1234_0340);
        spr_rd(16'h0B03, d); check_eq("rd_match", d, 32'h0000_6001);
        spr_rd(16'h0B83, d); check_eq("rd_trans", d, 32'h1234_0340);

        access(32'h0000_6abc, 1'b1, 1'b0, 1'b0, 1'b1);
        check_eq("ld_phys", phys, 32'h1234_0abc);
        check_eq("ld_miss", miss, 0);
        check_eq("ld_pf", pf, 0);
        check_eq("ld_ci", ci, 0);
        access(32'h0000_6abc, 1'b0, 1'b1, 1'b0, 1'b1);
        check_eq("ust_pf", pf, 1);
        access(32'h0000_6abc, 1'b0, 1'b1, 1'b1, 1'b1);
        check_eq("sst_pf", pf, 0);
        access(32'h0000_6abc, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("dis_phys", phys, 32'h0000_6abc);
        check_eq("dis_pf", pf, 0);

        // Same VPN in way 0 must take priority over way 1.
        spr_wr(16'h0A03, 32'h0000_6001);
        spr_wr(16'h0A83, 32'h5555_4300);
        access(32'h0000_6abc, 1'b1, 1'b0, 1'b0, 1'b1);
        check_eq("multi_phys", phys, 32'h5555_4abc);
        check_eq("multi_pf", pf, 1);
        spr_wr(16'h0A03, 32'h0000_0000);
        access(32'h0000_6abc, 1'b1, 1'b0, 1'b0, 1'b1);
        check_eq("w1_phys", phys, 32'h1234_0abc);

        spr_wr(16'h0A07, 32'h0000_E001);
        spr_wr(16'h0A87, 32'h0000_2002);
        access(32'h0000_E010, 1'b1, 1'b0, 1'b1, 1'b1);
        check_eq("ci_phys", phys, 32'h0000_2010);
        check_eq("ci_bit", ci, 1);

        spr_wr(16'h0C03, 32'h0000_6001);
        spr_rd(16'h0C03, d); check_eq("way2_rd", d, 0);

`ifdef MOR1KX_DMMU_HW_RELOAD_EN
        access(32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        spr_wr(16'h0800, 32'h0010_0000);
        spr_rd(16'h0800, d); check_eq("cr_rd", d, 32'h0010_0000);

        do_reload("fill0", 32'h0100_2000, 32'h0010_0004, 32'h0020_0000, 32'h0020_0004, 32'h0ABC_E4C0);
        check_eq("fill0_phys", phys, 32'h0ABC_E000);
        access(32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        spr_rd(16'h0A81, d); check_eq("fill0_trans", d, 32'h0ABC_E3C0);
        spr_rd(16'h0A01, d); check_eq("fill0_match", d, 32'h0100_2001);

        access(32'h0200_4000, 1'b1, 1'b0, 1'b1, 1'b1);
        wait_req("ptrpf");
        check_eq("ptrpf_addr", raddr, 32'h0010_0008);
        ack = 1'b1; rdat = 32'h0;
        @(negedge clk);
        ack = 1'b0; ld = 1'b0;
        #1;
        check_eq("ptrpf_rpf", rpf, 1);
        check_eq("ptrpf_req", req, 0);
        repeat (3) @(negedge clk);
        #1;
        check_eq("ptrpf_hold", rpf, 1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        #1;
        check_eq("ptrpf_clr", rpf, 0);

        access(32'h0200_4000, 1'b1, 1'b0, 1'b1, 1'b1);
        wait_req("ptepf");
        ack = 1'b1; rdat = 32'h0020_0000;
        @(negedge clk);
        ack = 1'b0;
        #1;
        check_eq("ptepf_addr", raddr, 32'h0020_0008);
        ack = 1'b1; rdat = 32'h1234_5000;
        @(negedge clk);
        ack = 1'b0; ld = 1'b0;
        #1;
        check_eq("ptepf_rpf", rpf, 1);
        check_eq("ptepf_miss", miss, 1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;

        do_reload("fa", 32'h0100_A000, 32'h0010_0004, 32'h0020_0000, 32'h0020_0014, 32'h1111_2400);
        access(32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        spr_rd(16'h0A05, d); check_eq("fa_way0", d, 32'h0100_A001);
        do_reload("fb", 32'h0200_A000, 32'h0010_0008, 32'h0020_0000, 32'h0020_0014, 32'h2222_4400);
        access(32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        spr_rd(16'h0B05, d); check_eq("fb_way1", d, 32'h0200_A001);
        do_reload("fc", 32'h0300_A000, 32'h0010_000C, 32'h0020_0000, 32'h0020_0014, 32'h3333_6400);
        access(32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        spr_rd(16'h0A05, d); check_eq("fc_way0", d, 32'h0300_A001);
        spr_rd(16'h0B05, d); check_eq("fc_way1", d, 32'h0200_A001);
        access(32'h0100_A000, 1'b0, 1'b0, 1'b1, 1'b1);
        check_eq("fa_evicted", miss, 1);
        access(32'h0300_A123, 1'b1, 1'b0, 1'b0, 1'b1);
        check_eq("fc_phys", phys, 32'h3333_6123);
        check_eq("fc_upf", pf, 1);

        access(32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        spr_wr(16'h0800, 32'h0000_0001);
        access(32'h0200_A000, 1'b0, 1'b0, 1'b1, 1'b1);
        check_eq("flush_b", miss, 1);
        access(32'h0100_2000, 1'b0, 1'b0, 1'b1, 1'b1);
        check_eq("flush_0", miss, 1);
        access(32'h0000_6abc, 1'b0, 1'b0, 1'b1, 1'b1);
        check_eq("flush_spr", miss, 1);

        spr_wr(16'h0800, 32'h0010_0000);
        access(32'h0100_2000, 1'b1, 1'b0, 1'b1, 1'b1);
        wait_req("abort");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; ld = 1'b0;
        #1;
        check_eq("abort_req", req, 0);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_miss", miss, 1);
`else
        access(32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        spr_wr(16'h0800, 32'h0010_0000);
        spr_rd(16'h0800, d); check_eq("cr_rd_off", d, 0);
        access(32'h0100_2000, 1'b1, 1'b0, 1'b1, 1'b1);
        check_eq("noreload_busy0", busy, 0);
        repeat (3) @(negedge clk);
        #1;
        check_eq("noreload_req", req, 0);
        check_eq("noreload_busy", busy, 0);
        check_eq("noreload_addr", raddr, 0);
        check_eq("noreload_rpf", rpf, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
